// File: rtl/dcm_ctrl_pkg.sv
// dcm_ctrl_pkg: shared sizes, register map constants and SPI FSM states for the motor controller.
package dcm_ctrl_pkg;
  localparam int NUM_CH      = 6;
  localparam int POS_W       = 24;
  localparam int PWM_DIV     = 4;
  localparam int STATUS_BASE = 0;
  localparam int CTRL_BASE   = 64;
  localparam int CH_STRIDE   = 4;
  localparam int FLAG_FAULT  = 0;
  localparam int FLAG_OTW    = 1;
  localparam int FLAG_AT     = 2;
  localparam int FLAG_MOV    = 3;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} spi_state_e;
endpackage

// File: rtl/dcm_channel.sv
// dcm_channel: one motor channel - encoder counting, direction latch, position compare, PWM gating, flags.
module dcm_channel
  import dcm_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_i,
  input  logic             fault_i,
  input  logic             otw_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_idx_i,
  input  logic [7:0]       wr_data_i,
  input  logic [7:0]       speed_i,
  input  logic [POS_W-1:0] target_i,
  input  logic [7:0]       pwm_cnt_i,
  output logic [31:0]      status_o,
  output logic             left_o,
  output logic             right_o,
  output logic             fault_o
);
  logic [2:0] pulse_q;
  logic [1:0] fault_s_q, otw_s_q, dir_q, dir_d;
  logic fault_q, fault_d, otw_q, otw_d, at, drive, pwm, rise, wf;
  logic [3:0] hi_q, hi_d;
  logic [7:0] flags;
  logic [POS_W-1:0] pos_q, pos_d, cnt, err;
  always_comb begin
    err = target_i - pos_q;
    at = pos_q == target_i;
    drive = |speed_i && !fault_q && !at;
    pwm = pwm_cnt_i < speed_i;
    right_o = drive & ~err[POS_W-1] & pwm;
    left_o = drive & err[POS_W-1] & pwm;
    rise = pulse_q[1] & ~pulse_q[2];
    dir_d = drive ? {1'b1, ~err[POS_W-1]} : dir_q;
    cnt = (rise && dir_q[1]) ? (dir_q[0] ? pos_q + 1'b1 : pos_q - 1'b1) : pos_q;
    // the SPI byte replaces only its own byte of the freshly counted value
    pos_d = {(wr_en_i && wr_idx_i == 2'd1) ? wr_data_i : cnt[23:16],
             (wr_en_i && wr_idx_i == 2'd2) ? wr_data_i : cnt[15:8],
             (wr_en_i && wr_idx_i == 2'd3) ? wr_data_i : cnt[7:0]};
    wf = wr_en_i && wr_idx_i == 2'd0;
    fault_d = (wf ? wr_data_i[FLAG_FAULT] : fault_q) | fault_s_q[1];
    otw_d = (wf ? wr_data_i[FLAG_OTW] : otw_q) | otw_s_q[1];
    hi_d = wf ? wr_data_i[7:4] : hi_q;
    flags = {hi_q, 4'b0000};
    flags[FLAG_FAULT] = fault_q;
    flags[FLAG_OTW] = otw_q;
    flags[FLAG_AT] = at;
    flags[FLAG_MOV] = drive;
    status_o = {flags, pos_q};
    fault_o = fault_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q <= '0;
      fault_s_q <= '0;
      otw_s_q <= '0;
      dir_q <= '0;
      fault_q <= 1'b0;
      otw_q <= 1'b0;
      hi_q <= '0;
      pos_q <= '0;
    end else begin
      pulse_q <= {pulse_q[1:0], pulse_i};
      fault_s_q <= {fault_s_q[0], fault_i};
      otw_s_q <= {otw_s_q[0], otw_i};
      dir_q <= dir_d;
      fault_q <= fault_d;
      otw_q <= otw_d;
      hi_q <= hi_d;
      pos_q <= pos_d;
    end
  end
endmodule

// File: rtl/dcm_ctrl.sv
// dcm_ctrl: SPI-mapped 6-channel DC motor position controller.
// Holds the SPI slave, the 128-byte register RAM, the shared PWM counter and the channel array.
module dcm_ctrl
  import dcm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ss,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [NUM_CH-1:0] motor_left,
  output logic [NUM_CH-1:0] motor_right,
  output logic [NUM_CH-1:0] motor_reset,
  input  logic [NUM_CH-1:0] motor_pulse,
  input  logic [NUM_CH-1:0] motor_fault,
  input  logic [NUM_CH-1:0] motor_otw
);
  localparam int DIV_W = $clog2(PWM_DIV);
  localparam logic [6:0] ST_END = 7'(STATUS_BASE + NUM_CH * CH_STRIDE);
  spi_state_e st_q, st_d;
  logic [1:0] ss_q, mosi_q;
  logic [2:0] sck_q, cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d, addr_q, addr_d;
  logic [7:0] sh_q, sh_d, full, rd_byte, pwm_q;
  logic rw_q, rw_d, miso_q, miso_d, load_q, load_d, wr_en, snap_en, st_wr, run_q, ss_s, rise, fall;
  logic [DIV_W-1:0] div_q;
  logic [7:0] mem_q [128];
  logic [31:0] snap_q [NUM_CH];
  logic [31:0] status [NUM_CH];
  logic [NUM_CH-1:0] fault;
  assign ss_s = ss_q[1];
  assign rise = sck_q[1] & ~sck_q[2];
  assign fall = ~sck_q[1] & sck_q[2];
  assign full = {rx_q, mosi_q[1]};
  assign st_wr = wr_en && addr_q >= 7'(STATUS_BASE) && addr_q < ST_END;
  // status reads come from the snapshot so multi-byte positions are coherent
  assign rd_byte = (addr_q >= 7'(STATUS_BASE) && addr_q < ST_END) ?
                   snap_q[addr_q[4:2]][{~addr_q[1:0], 3'b000} +: 8] : mem_q[addr_q];
  assign spi_miso = miso_q;
  assign motor_reset = fault | {NUM_CH{~run_q}};
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    rw_d = rw_q;
    addr_d = addr_q;
    sh_d = load_q ? rd_byte : sh_q;
    miso_d = miso_q;
    load_d = 1'b0;
    wr_en = 1'b0;
    snap_en = 1'b0;
    if (ss_s) begin
      st_d = S_IDLE;
      cnt_d = '0;
      sh_d = '0;
      miso_d = 1'b0;
    end else begin
      if (st_q == S_IDLE) st_d = S_CMD;
      if (fall) begin
        miso_d = sh_q[7];
        sh_d = {sh_q[6:0], 1'b0};
      end
      if (rise) begin
        rx_d = full[6:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7 && st_q == S_DATA) begin
          wr_en = rw_q;
          addr_d = addr_q + 7'd1;
          load_d = ~rw_q;
        end else if (cnt_q == 3'd7) begin
          rw_d = full[7];
          addr_d = full[6:0];
          st_d = S_DATA;
          load_d = ~full[7];
          snap_en = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_q <= 2'b11;
      sck_q <= 3'b111;
      mosi_q <= '0;
      st_q <= S_IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      sh_q <= '0;
      miso_q <= 1'b0;
      load_q <= 1'b0;
      div_q <= '0;
      pwm_q <= '0;
      run_q <= 1'b0;
    end else begin
      ss_q <= {ss_q[0], spi_ss};
      sck_q <= {sck_q[1:0], spi_clk};
      mosi_q <= {mosi_q[0], spi_mosi};
      st_q <= st_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      sh_q <= sh_d;
      miso_q <= miso_d;
      load_q <= load_d;
      div_q <= (div_q == DIV_W'(PWM_DIV - 1)) ? '0 : div_q + 1'b1;
      pwm_q <= pwm_q + 8'(div_q == DIV_W'(PWM_DIV - 1));
      run_q <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) mem_q[i] <= '0;
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else begin
      if (wr_en) mem_q[addr_q] <= full;
      if (snap_en) for (int i = 0; i < NUM_CH; i++) snap_q[i] <= status[i];
    end
  end
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    dcm_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .pulse_i   (motor_pulse[n]),
      .fault_i   (motor_fault[n]),
      .otw_i     (motor_otw[n]),
      .wr_en_i   (st_wr && addr_q[4:2] == 3'(n)),
      .wr_idx_i  (addr_q[1:0]),
      .wr_data_i (full),
      .speed_i   (mem_q[CTRL_BASE + CH_STRIDE * n]),
      .target_i  ({mem_q[CTRL_BASE + CH_STRIDE * n + 1], mem_q[CTRL_BASE + CH_STRIDE * n + 2],
                   mem_q[CTRL_BASE + CH_STRIDE * n + 3]}),
      .pwm_cnt_i (pwm_q),
      .status_o  (status[n]),
      .left_o    (motor_left[n]),
      .right_o   (motor_right[n]),
      .fault_o   (fault[n])
    );
  end
endmodule

// File: tb/tb_dcm_ctrl.sv
// tb_dcm_ctrl: bit-banged SPI host with a read-data scoreboard, encoder/fault stimulus and PWM duty checks.
module tb_dcm_ctrl;
  localparam int HALF = 50;
  logic clk = 1'b0, reset = 1'b1, spi_ss = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0, spi_miso;
  logic [5:0] motor_left, motor_right, motor_reset;
  logic [5:0] motor_pulse = '0, motor_fault = '0, motor_otw = '0;
  int nvec = 0, nfail = 0, l, r;
  logic [7:0] exp_q[$];
  typedef struct {logic [6:0] addr; logic [7:0] wdata; logic [7:0] exp;} vec_t;
  vec_t tbl[11];
  always #5 clk = ~clk;
  dcm_ctrl dut (
    .clk(clk), .reset(reset), .spi_ss(spi_ss), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .motor_left(motor_left), .motor_right(motor_right),
    .motor_reset(motor_reset), .motor_pulse(motor_pulse), .motor_fault(motor_fault),
    .motor_otw(motor_otw)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_clk = 1'b0;
      spi_mosi = tx[i];
      #HALF;
      spi_clk = 1'b1;
      rx[i] = spi_miso;
      #HALF;
    end
  endtask
  task automatic ss_lo;
    spi_ss = 1'b0;
    #HALF;
  endtask
  task automatic ss_hi;
    spi_ss = 1'b1;
    #(4 * HALF);
  endtask
  task automatic wr(input logic [6:0] a, input int n, input logic [31:0] d);
    logic [7:0] rx;
    ss_lo();
    spi_bits({1'b1, a}, 8, rx);
    for (int i = n - 1; i >= 0; i--) spi_bits(d[8*i +: 8], 8, rx);
    ss_hi();
  endtask
  task automatic rd(input logic [6:0] a, input int n, input string name);
    logic [7:0] rx;
    ss_lo();
    spi_bits({1'b0, a}, 8, rx);
    chk({name, " cmd-phase miso"}, rx, 8'h00);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL %s byte %0d: got %0h, no expected value queued", name, i, rx);
      end else chk($sformatf("%s byte %0d", name, i), rx, exp_q.pop_front());
    end
    ss_hi();
  endtask
  task automatic duty(input int ch, output int lc, output int rc);
    lc = 0;
    rc = 0;
    repeat (1024) begin
      @(negedge clk);
      lc += int'(motor_left[ch]);
      rc += int'(motor_right[ch]);
    end
  endtask
  task automatic pulses(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1 motor_pulse[ch] = 1'b1;
      repeat (3) @(posedge clk);
      #1 motor_pulse[ch] = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (8) @(posedge clk);
  endtask
  initial begin
    logic [7:0] dummy;
    tbl[0]  = '{7'd20,  8'h0F, 8'h07};
    tbl[1]  = '{7'd20,  8'hF0, 8'hF4};
    tbl[2]  = '{7'd20,  8'h00, 8'h04};
    tbl[3]  = '{7'd23,  8'h55, 8'h55};
    tbl[4]  = '{7'd21,  8'h12, 8'h12};
    tbl[5]  = '{7'd22,  8'hAB, 8'hAB};
    tbl[6]  = '{7'd20,  8'h00, 8'h00};
    tbl[7]  = '{7'd68,  8'h33, 8'h33};
    tbl[8]  = '{7'd40,  8'h3C, 8'h3C};
    tbl[9]  = '{7'd91,  8'hC3, 8'hC3};
    tbl[10] = '{7'd127, 8'h7E, 8'h7E};
    #1 reset = 1'b0;
    #1;
    chk("reset motor_reset", motor_reset, 6'h3F);
    chk("reset motor_left", motor_left, 6'h00);
    chk("reset motor_right", motor_right, 6'h00);
    chk("reset spi_miso", spi_miso, 1'b0);
    #20 reset = 1'b1;
    repeat (5) @(posedge clk);
    ss_lo();
    spi_bits(8'h80, 8, dummy);
    for (int i = 0; i < 128; i++) spi_bits(8'h00, 8, dummy);
    ss_hi();
    chk("post-clear motor_reset", motor_reset, 6'h00);
    chk("post-clear motor_left", motor_left, 6'h00);
    chk("post-clear motor_right", motor_right, 6'h00);
    for (int a = 0; a < 128; a++) exp_q.push_back((a < 24 && a % 4 == 0) ? 8'h04 : 8'h00);
    rd(7'h00, 128, "zero readback");
    for (int i = 0; i < 11; i++) begin
      wr(tbl[i].addr, 1, {24'h0, tbl[i].wdata});
      exp_q.push_back(tbl[i].exp);
      rd(tbl[i].addr, 1, $sformatf("vec%0d @%0d", i, tbl[i].addr));
    end
    wr(7'h40, 4, {8'd250, 8'h00, 8'h09, 8'hC4});
    repeat (10) @(posedge clk);
    duty(0, l, r);
    chk("ch0 fwd right duty", r, 1000);
    chk("ch0 fwd left duty", l, 0);
    pulses(0, 2500);
    duty(0, l, r);
    chk("ch0 at target right", r, 0);
    chk("ch0 at target left", l, 0);
    exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h09); exp_q.push_back(8'hC4);
    rd(7'h00, 4, "ch0 at 2500");
    wr(7'h41, 3, 32'h0);
    repeat (10) @(posedge clk);
    duty(0, l, r);
    chk("ch0 rev left duty", l, 1000);
    chk("ch0 rev right duty", r, 0);
    pulses(0, 1250);
    exp_q.push_back(8'h08); exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'hE2);
    rd(7'h00, 4, "ch0 at 1250");
    wr(7'h40, 1, 32'h0);
    duty(0, l, r);
    chk("ch0 speed0 left", l, 0);
    chk("ch0 speed0 right", r, 0);
    pulses(0, 1250);
    exp_q.push_back(8'h04); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rd(7'h00, 4, "ch0 coast to 0");
    wr(7'h48, 4, {8'd100, 8'h00, 8'h00, 8'h05});
    repeat (10) @(posedge clk);
    duty(2, l, r);
    chk("ch2 right duty", r, 400);
    chk("ch2 left duty", l, 0);
    @(posedge clk); #1 motor_fault[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 motor_fault[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("ch2 fault motor_reset", motor_reset, 6'b000100);
    duty(2, l, r);
    chk("ch2 fault right off", r, 0);
    exp_q.push_back(8'h01);
    rd(7'h08, 1, "ch2 fault flags");
    wr(7'h08, 1, 32'h0);
    chk("ch2 cleared motor_reset", motor_reset, 6'h00);
    exp_q.push_back(8'h08);
    rd(7'h08, 1, "ch2 cleared flags");
    duty(2, l, r);
    chk("ch2 resumed right duty", r, 400);
    @(posedge clk); #1 motor_otw[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 motor_otw[3] = 1'b0;
    repeat (6) @(posedge clk);
    exp_q.push_back(8'h06);
    rd(7'h0C, 1, "ch3 otw flags");
    chk("otw motor_reset", motor_reset, 6'h00);
    wr(7'h7F, 2, {16'h0, 8'h11, 8'hA0});
    exp_q.push_back(8'h11); exp_q.push_back(8'hA4);
    rd(7'h7F, 2, "addr wrap");
    ss_lo();
    spi_bits(8'h9E, 8, dummy);
    spi_bits(8'h5A, 8, dummy);
    spi_bits(8'hFF, 4, dummy);
    ss_hi();
    chk("abort miso idle", spi_miso, 1'b0);
    ss_lo();
    spi_bits(8'hFF, 3, dummy);
    ss_hi();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
    rd(7'h1E, 2, "abort partial");
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
